// File: rtl/sap_serial_pkg.sv
// Shared constants for the SAP-U serial path (transmitter now, receiver later).
// State encodings, line levels and a width helper for the bit timer.
package sap_serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Timer width is max(1, clog2(clks_per_bit)) so a 1-clock bit still has a counter.
  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear.
// o_tick marks the last cycle of a serial bit.
module bit_timer
  import sap_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // Count up, wrap at the end of each bit, hold at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: framed parallel-to-serial transmitter (start, data LSB-first,
// optional even parity, stop). Parity is compiled in with SERIAL_TX_PARITY_EN.
// o_tx / o_not_tx are registered from the next-state decode so the line
// changes in the cycle right after the edge that moves the FSM.
module serial_tx
  import sap_serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_not_tx,
  output logic                  o_busy
);

  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  r_tx;
  logic                  r_not_tx;

  logic [2:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_tx_nxt;
  logic                  w_tick;
  logic                  w_accept;

`ifdef SERIAL_TX_PARITY_EN
  logic r_par;
`endif

  assign o_ready  = (r_state == ST_IDLE);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_tx     = r_tx;
  assign o_not_tx = r_not_tx;
  assign w_accept = (r_state == ST_IDLE) && i_valid;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(r_state == ST_IDLE),
    .o_tick (w_tick)
  );

  // Next-state, shift-register and index decode.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = i_data;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_tick) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line level for the state being entered, registered below.
  always_comb begin
    w_tx_nxt = LINE_IDLE;
    case (w_state_nxt)
      ST_START:  w_tx_nxt = LINE_START;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = r_par;
`endif
      default:   w_tx_nxt = LINE_IDLE;
    endcase
  end

  // FSM, datapath and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_tx     <= LINE_IDLE;
      r_not_tx <= ~LINE_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_idx    <= w_idx_nxt;
      r_tx     <= w_tx_nxt;
      r_not_tx <= ~w_tx_nxt;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity taken from the word as latched at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^i_data;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Expected frames are written by hand as {stop, [parity], data, start}.
module tb_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_not_tx;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  serial_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_tx    (o_tx),
    .o_not_tx(o_not_tx),
    .o_busy  (o_busy)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks {o_tx,o_not_tx,o_ready,o_busy} for every cycle of a frame, starting
  // at the sample point right after the handshake edge; returns one sample
  // point past the last frame cycle.
  task automatic frame_check(input logic [10:0] seq, input int nb, input string tag);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s bit%0d cyc%0d", tag, b, c),
            {28'd0, o_tx, o_not_tx, o_ready, o_busy},
            {28'd0, seq[b], ~seq[b], 2'b01});
        step();
      end
    end
  endtask

  task automatic idle_check(input string tag);
    chk(tag, {28'd0, o_tx, o_not_tx, o_ready, o_busy}, 32'b1010);
  endtask

  initial begin
    rst_n   = 1'b1;
    i_data  = 8'h00;
    i_valid = 1'b0;

    // Reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #1 idle_check("reset_noclk");
    #1 rst_n = 1'b1;
    step();
    idle_check("idle_after_reset");

    // 0xA5
    i_data = 8'hA5; i_valid = 1'b1;
    step();
    i_valid = 1'b0; i_data = 8'h00;
`ifdef SERIAL_TX_PARITY_EN
    frame_check({1'b1, 1'b0, 8'hA5, 1'b0}, 11, "a5_par");
`else
    frame_check({1'b1, 8'hA5, 1'b0}, 10, "a5");
`endif
    idle_check("a5_end_idle");
    step();

    // 0x07
    i_data = 8'h07; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    frame_check({1'b1, 1'b1, 8'h07, 1'b0}, 11, "07_par");
`else
    frame_check({1'b1, 8'h07, 1'b0}, 10, "07");
`endif
    idle_check("07_end_idle");
    step();

    // Busy: valid held, data changes mid-frame.
    i_data = 8'h3C; i_valid = 1'b1;
    step();
    i_data = 8'hFF;
`ifdef SERIAL_TX_PARITY_EN
    frame_check({1'b1, 1'b0, 8'h3C, 1'b0}, 11, "3c_busy_par");
`else
    frame_check({1'b1, 8'h3C, 1'b0}, 10, "3c_busy");
`endif
    idle_check("3c_first_idle");
    step();
    i_valid = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    frame_check({1'b1, 1'b0, 8'hFF, 1'b0}, 11, "ff_par");
`else
    frame_check({1'b1, 8'hFF, 1'b0}, 10, "ff");
`endif
    idle_check("ff_end_idle");
    step();

    // Reset during DATA bit 3 of a 0x00 frame (line low there).
    i_data = 8'h00; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (17) step();
    chk("mid_frame_low", {31'd0, o_tx}, 32'd0);
    #1 rst_n = 1'b0;
    #1 idle_check("mid_frame_reset");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      idle_check($sformatf("post_reset_idle%0d", i));
    end

    // Fresh frame after the aborted one.
    i_data = 8'hA5; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    frame_check({1'b1, 1'b0, 8'hA5, 1'b0}, 11, "a5_again_par");
`else
    frame_check({1'b1, 8'hA5, 1'b0}, 10, "a5_again");
`endif
    idle_check("a5_again_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial transmitter for the SAP-U output path. It accepts a DATA_WIDTH-bit word from the output register through a valid/ready handshake and shifts it out on a single line as a framed serial stream: start bit, data LSB-first, optional parity, stop bit. It is the driving end of the single-bit line that the `d_flip_flop` chain samples one bit per clock. `o_tx` and its complement `o_not_tx` are registered so the line is glitch-free.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, at least 1.
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held, at least 1.
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `i_data`  input  DATA_WIDTH: word to transmit; sampled only at handshake.
- `i_valid`  input  1: `i_data` is valid.
- `o_ready`  output  1: block can accept a word; high only in IDLE.
- `o_tx`  output  1: serial line; idle level is 1.
- `o_not_tx`  output  1: always the complement of `o_tx`.
- `o_busy`  output  1: a frame is in progress, meaning the state is not IDLE.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE:
  - `o_tx`=1, `o_ready`=1.
  - On a rising edge with `i_valid`=1, the block latches `i_data` into the shift register, clears the bit timer and goes to START.
- START:
  - `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- DATA:
  - `o_tx` = shift register bit 0, held for CLKS_PER_BIT cycles.
  - At the end of each bit, shift right and increment the index.
  - After bit DATA_WIDTH-1, go to PARITY if it is compiled in, otherwise to STOP.
- PARITY: `o_tx` = even parity, the XOR of the latched word, held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `o_tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit timer: counts 0 to CLKS_PER_BIT-1 and wraps; width is max(1, clog2(CLKS_PER_BIT)). The end-of-bit strobe fires when the timer reaches CLKS_PER_BIT-1.
- Bit index: width is clog2(DATA_WIDTH+1), with no overflow past DATA_WIDTH.
- `i_valid` outside IDLE is ignored: no accept and no effect.
- Changes on `i_data` after the handshake do not affect the current frame.
- Parity calculation uses the latched copy, not live `i_data`.

## Timing
- Reset values, applied immediately on `rst_n`=0 with no clock required:
  - state = IDLE
  - `o_tx`=1, `o_not_tx`=0
  - `o_ready`=1, `o_busy`=0
  - shift register, timer and index = 0
- Reset mid-frame: the line returns to 1 at once and the frame is discarded. No partial resend happens after release.
- Handshake at rising edge k:
  - `o_ready` and `o_busy` change in the cycle after edge k.
  - `o_tx` falls in the cycle after edge k (registered, 1-cycle latency).
- Frame length is (2 + DATA_WIDTH + P) × CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- After STOP ends, the block is in IDLE for at least one cycle. The minimum line-high time between frames is therefore CLKS_PER_BIT+1 cycles.
- `o_ready` depends only on state, never combinationally on `i_valid`.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; every edge is an end-of-bit strobe.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - the PARITY state exists and an even-parity bit is inserted between DATA and STOP
  - frame is DATA_WIDTH+3 bits
- Not defined:
  - the PARITY state and its logic are removed
  - DATA goes directly to STOP
  - frame is DATA_WIDTH+2 bits

## Structure
- Shared package `sap_serial_pkg` holds:
  - state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit
  - line-level constants `LINE_IDLE`=1 and `LINE_START`=0
- These constants are shared with a future serial receiver.
- One sub-module `bit_timer`:
  - parameter CLKS_PER_BIT
  - inputs `clk`, `rst_n`, `i_clear`
  - output `o_tick` (end-of-bit strobe)
- The FSM, shift register and parity logic stay in `serial_tx`.

## Test plan
All scenarios use DATA_WIDTH=8 and CLKS_PER_BIT=4.
- Reset with no clock: `rst_n`=0 → `o_tx`=1, `o_not_tx`=0, `o_ready`=1, `o_busy`=0.
- Send 0xA5 without parity:
  - `o_tx` bit sequence is 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles
  - frame is 40 cycles, then `o_ready`=1
- Send 0xA5 with `SERIAL_TX_PARITY_EN`: the parity bit is 0 (four ones), frame is 44 cycles.
- Send 0x07 with parity: the parity bit is 1.
- Busy behaviour:
  - hold `i_valid`=1 and change `i_data` to 0xFF during a 0x3C frame → 0x3C is sent intact
  - 0xFF is accepted only on the first IDLE cycle, after 4 stop cycles plus 1 idle cycle
- Assert `rst_n`=0 during DATA bit 3 → `o_tx`=1 immediately; after release the line stays 1 and `o_ready`=1 until a new handshake.
